// File: rtl/camera_pkg.sv
// Shared types and helpers for the OV7670 capture path: geometry, FSM encoding, pixel packing.
package camera_pkg;
    localparam int SCREEN_WIDTH  = 176;
    localparam int SCREEN_HEIGHT = 144;
    localparam int CNT_W         = 10;
    localparam int ADDR_W        = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LINE,
        BYTE_HI,
        BYTE_LO
    } cap_state_t;

    // RGB565 byte pair -> RGB332: top red bits, top green bits of the high byte, top blue bits.
    function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// One-flop history of a framing signal with combinational rise/fall against the current level.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) din_q <= 1'b0;
        else        din_q <= din;
    end

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;
endmodule

// File: rtl/camera_capture.sv
// OV7670 capture: packs RGB565 byte pairs into RGB332 frame-buffer writes one cycle after the low byte,
// tracks X/Y/flat addresses and reports line/frame length errors at each frame end.
module camera_capture
    import camera_pkg::*;
#(
    parameter int WIDTH  = SCREEN_WIDTH,
    parameter int HEIGHT = SCREEN_HEIGHT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        cam_data,
    input  logic              href,
    input  logic              vsync,
    output logic              w_en,
    output logic [7:0]        pixel_out,
    output logic [CNT_W-1:0]  x_addr,
    output logic [CNT_W-1:0]  y_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);
    localparam logic [CNT_W-1:0]  WIDTH_C  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  HEIGHT_C = CNT_W'(HEIGHT);
    localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);

    logic href_rise_unused, href_fall, vsync_rise, vsync_fall;

    cap_state_t       state, state_n;
    logic [CNT_W-1:0] col, col_n, row, row_n;
    logic [7:0]       hi, hi_n;
    logic             err_acc, err_n;
    logic             wr, done, done_err;

    // Lines start on the HREF level, so only the falling edge of HREF matters.
    sync_edge_detect u_href_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (href),
        .rise (href_rise_unused),
        .fall (href_fall)
    );

    sync_edge_detect u_vsync_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (vsync),
        .rise (vsync_rise),
        .fall (vsync_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        col_n    = col;
        row_n    = row;
        hi_n     = hi;
        err_n    = err_acc;
        wr       = 1'b0;
        done     = 1'b0;
        done_err = 1'b0;
        case (state)
            IDLE: begin
                if (vsync_fall) begin
                    state_n = WAIT_LINE;
                    row_n   = '0;
                    err_n   = 1'b0;
                end
            end
            default: begin
                if (vsync_rise) begin
                    // An open line at frame end is an aborted line.
                    done     = 1'b1;
                    done_err = err_acc | (state != WAIT_LINE) | (row != HEIGHT_C);
                    state_n  = IDLE;
                end else if (href_fall && state != WAIT_LINE) begin
                    if (col != WIDTH_C || state == BYTE_LO) err_n = 1'b1;
                    row_n   = sat_inc(row);
                    state_n = WAIT_LINE;
                end else if (href && !vsync) begin
                    case (state)
                        WAIT_LINE: begin
                            hi_n    = cam_data;
                            col_n   = '0;
                            state_n = BYTE_LO;
                        end
                        BYTE_LO: begin
                            wr      = (col < WIDTH_C) && (row < HEIGHT_C);
                            col_n   = sat_inc(col);
                            state_n = BYTE_HI;
                        end
                        BYTE_HI: begin
                            hi_n    = cam_data;
                            state_n = BYTE_LO;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            hi         <= '0;
            err_acc    <= 1'b0;
            w_en       <= 1'b0;
            pixel_out  <= '0;
            x_addr     <= '0;
            y_addr     <= '0;
            w_addr     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            col        <= col_n;
            row        <= row_n;
            hi         <= hi_n;
            err_acc    <= err_n;
            w_en       <= wr;
            frame_done <= done;
            if (wr) begin
                pixel_out <= rgb565_to_rgb332(hi, cam_data);
                x_addr    <= col;
                y_addr    <= row;
                w_addr    <= ADDR_W'(row) * WIDTH_A + ADDR_W'(col);
            end
            if (done) begin
                frame_err <= done_err;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture with a frame-level reference model and a per-cycle compare process.
module tb_camera_capture;
    import camera_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  cam_data = 8'h00;
    logic        href = 1'b0;
    logic        vsync = 1'b1;
    logic        w_en;
    logic [7:0]  pixel_out;
    logic [9:0]  x_addr, y_addr;
    logic [14:0] w_addr;
    logic        frame_done, frame_err;
    logic [7:0]  frame_cnt;

    camera_capture #(.WIDTH(SCREEN_WIDTH), .HEIGHT(SCREEN_HEIGHT)) dut (
        .clk(clk), .rst_n(rst_n), .cam_data(cam_data), .href(href), .vsync(vsync),
        .w_en(w_en), .pixel_out(pixel_out), .x_addr(x_addr), .y_addr(y_addr), .w_addr(w_addr),
        .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [9:0] x; logic [9:0] y; logic [14:0] a; logic [7:0] p; int due; } wr_exp_t;
    typedef struct { logic err; logic [7:0] cnt; int due; } done_exp_t;
    typedef logic [7:0] bytes_t[$];

    wr_exp_t    exp_q[$];
    done_exp_t  done_q[$];
    logic [7:0] pix_log[$];

    int checks = 0, failures = 0, cyc = 0;
    int n_wr = 0, n_sel = 0, n_done = 0, sel_row = 0, line_seq = 0;
    int max_x = 0, last_addr = 0;
    // Frame-level model state
    bit cap_on = 0, m_err = 0, m_open = 0;
    int m_row = 0, m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        wr_exp_t   e;
        done_exp_t d;
        forever begin
            @(posedge clk);
            #1;
            if (w_en) begin
                n_wr++;
                last_addr = int'(w_addr);
                if (int'(y_addr) == sel_row) n_sel++;
                if (int'(x_addr) > max_x) max_x = int'(x_addr);
                pix_log.push_back(pixel_out);
                if (exp_q.size() == 0) check("wen_expected", 64'(exp_q.size()), 64'(1));
                else begin
                    e = exp_q.pop_front();
                    check("wr_data", 64'({x_addr, y_addr, w_addr, pixel_out}), 64'({e.x, e.y, e.a, e.p}));
                    check("wr_cycle", 64'(cyc), 64'(e.due));
                end
            end
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                void'(exp_q.pop_front());
                check("wen_missing", 64'(w_en), 64'(1));
            end
            if (frame_done) begin
                n_done++;
                if (done_q.size() == 0) check("done_expected", 64'(done_q.size()), 64'(1));
                else begin
                    d = done_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(d.due));
                    check("done_status", 64'({frame_err, frame_cnt}), 64'({d.err, d.cnt}));
                end
            end
            while (done_q.size() > 0 && done_q[0].due <= cyc) begin
                void'(done_q.pop_front());
                check("done_missing", 64'(frame_done), 64'(1));
            end
        end
    end

    task automatic drive_line(input bytes_t b, input bit close_line);
        logic [7:0] prev = 8'h00;
        wr_exp_t    e;
        for (int i = 0; i < b.size(); i++) begin
            @(negedge clk);
            href = 1'b1;
            cam_data = b[i];
            if (i % 2 == 1 && cap_on && (i / 2) < SCREEN_WIDTH && m_row < SCREEN_HEIGHT) begin
                e.x = 10'(i / 2);
                e.y = 10'(m_row);
                e.a = 15'(m_row * SCREEN_WIDTH + i / 2);
                e.p = rgb565_to_rgb332(prev, b[i]);
                e.due = cyc + 1;
                exp_q.push_back(e);
            end
            prev = b[i];
        end
        if (close_line) begin
            @(negedge clk);
            href = 1'b0;
            if (cap_on) begin
                if (b.size() != 2 * SCREEN_WIDTH) m_err = 1;
                m_row++;
            end
        end else begin
            m_open = cap_on && (b.size() > 0);
        end
    endtask

    task automatic line(input int n, input bit close_line);
        bytes_t b;
        for (int i = 0; i < n; i++) b.push_back(8'((i * 37 + line_seq * 11 + 5) % 256));
        line_seq++;
        drive_line(b, close_line);
    endtask

    task automatic frame_start();
        @(negedge clk);
        vsync = 1'b0;
        cap_on = 1; m_row = 0; m_err = 0; m_open = 0;
        @(negedge clk);
    endtask

    task automatic frame_end();
        done_exp_t d;
        @(negedge clk);
        vsync = 1'b1;
        href = 1'b0;
        if (cap_on) begin
            d.err = m_err | m_open | (m_row != SCREEN_HEIGHT);
            d.cnt = 8'(m_cnt + 1);
            d.due = cyc + 1;
            done_q.push_back(d);
            m_cnt++;
        end
        cap_on = 0; m_open = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_w_en"}, 64'(w_en), 64'(0));
        check({tag, "_pixel_out"}, 64'(pixel_out), 64'(0));
        check({tag, "_x_addr"}, 64'(x_addr), 64'(0));
        check({tag, "_y_addr"}, 64'(y_addr), 64'(0));
        check({tag, "_w_addr"}, 64'(w_addr), 64'(0));
        check({tag, "_frame_done"}, 64'(frame_done), 64'(0));
        check({tag, "_frame_err"}, 64'(frame_err), 64'(0));
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(0));
    endtask

    initial begin
        bytes_t pb;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pixel pack: E7,18 -> FF and 00,00 -> 00
        pix_log.delete();
        pb = '{8'hE7, 8'h18, 8'h00, 8'h00};
        frame_start();
        drive_line(pb, 1);
        frame_end();
        check("pack_count", 64'(pix_log.size()), 64'(2));
        if (pix_log.size() == 2) begin
            check("pack_e7_18", 64'(pix_log[0]), 64'(8'hFF));
            check("pack_00_00", 64'(pix_log[1]), 64'(8'h00));
        end
        check("pack_frame_cnt", 64'(frame_cnt), 64'(1));

        // Odd line on row 5
        sel_row = 5; n_sel = 0;
        frame_start();
        repeat (5) line(352, 1);
        line(351, 1);
        frame_end();
        check("odd_row5_writes", 64'(n_sel), 64'(175));
        check("odd_frame_err", 64'(frame_err), 64'(1));

        // Long line on row 0 is clipped at X=175
        sel_row = 0; n_sel = 0; max_x = 0;
        frame_start();
        line(360, 1);
        line(352, 1);
        frame_end();
        check("long_row0_writes", 64'(n_sel), 64'(176));
        check("long_max_x", 64'(max_x), 64'(175));
        check("long_frame_err", 64'(frame_err), 64'(1));

        // VSYNC rise mid-line at row 70, then HREF under VSYNC is ignored
        n_done = 0;
        frame_start();
        repeat (70) line(2, 1);
        line(100, 0);
        frame_end();
        check("abort_done_pulses", 64'(n_done), 64'(1));
        check("abort_frame_err", 64'(frame_err), 64'(1));
        check("abort_frame_cnt", 64'(frame_cnt), 64'(4));
        n_wr = 0;
        line(20, 1);
        repeat (3) @(negedge clk);
        check("vsync_high_writes", 64'(n_wr), 64'(0));

        // Reset mid-frame at row 40
        frame_start();
        repeat (40) line(2, 1);
        line(60, 0);
        @(negedge clk);
        rst_n = 1'b0;
        href = 1'b0;
        cap_on = 0; m_open = 0; m_cnt = 0;
        #1 check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_wr = 0; n_done = 0;
        repeat (103) line(2, 1);
        frame_end();
        check("post_reset_writes", 64'(n_wr), 64'(0));
        check("post_reset_done", 64'(n_done), 64'(0));

        // Nominal full frame
        n_wr = 0; n_done = 0; last_addr = 0;
        frame_start();
        repeat (SCREEN_HEIGHT) line(2 * SCREEN_WIDTH, 1);
        frame_end();
        check("nominal_writes", 64'(n_wr), 64'(25344));
        check("nominal_last_addr", 64'(last_addr), 64'(25343));
        check("nominal_done_pulses", 64'(n_done), 64'(1));
        check("nominal_frame_err", 64'(frame_err), 64'(0));
        check("nominal_frame_cnt", 64'(frame_cnt), 64'(1));

        // Frame counter wrap
        repeat (254) begin
            frame_start();
            frame_end();
        end
        check("cnt_255", 64'(frame_cnt), 64'(255));
        frame_start();
        frame_end();
        check("cnt_wrap", 64'(frame_cnt), 64'(0));

        repeat (3) @(negedge clk);
        check("writes_outstanding", 64'(exp_q.size()), 64'(0));
        check("done_outstanding", 64'(done_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/camera_capture.md
# camera_capture

Front-end capture stage for the OV7670 camera path. It samples the camera's 8-bit byte stream under HREF/VSYNC framing and packs each RGB565 byte pair into one RGB332 pixel. It generates X/Y and flat frame-buffer write addresses and flags malformed lines and frames. Its outputs feed the M9K frame buffer, whose read side drives the image processor (PIXEL_IN, VGA_PIXEL_X/Y) at 176x144.

## Interface
- WIDTH, 176: active pixels per line
- HEIGHT, 144: active lines per frame
- CLK  in  1  camera PCLK; all logic on posedge
- RST_N  in  1  asynchronous, active-low reset
- CAM_DATA  in  8  camera byte bus
- HREF  in  1  high during active line bytes
- VSYNC  in  1  high during vertical blanking; falling edge = frame start, rising edge = frame end
- W_EN  out  1  one-cycle write strobe to frame buffer
- PIXEL_OUT  out  8  RGB332 pixel, valid with W_EN
- X_ADDR  out  10  pixel column, valid with W_EN
- Y_ADDR  out  10  pixel row, valid with W_EN
- W_ADDR  out  15  Y_ADDR*WIDTH+X_ADDR, valid with W_EN
- FRAME_DONE  out  1  one-cycle pulse at end of a captured frame
- FRAME_ERR  out  1  error status of last completed frame, updated with FRAME_DONE
- FRAME_CNT  out  8  completed frames, wraps 255->0

## Operation
- Edge detect: registered copies HREF_q, VSYNC_q; rise = cur & ~q, fall = ~cur & q.
- FSM states: IDLE, WAIT_LINE, BYTE_HI, BYTE_LO.
  - IDLE: leave only on a VSYNC falling edge. Enter WAIT_LINE, row=0, clear error accumulator. A partial frame after reset is discarded.
  - WAIT_LINE: HREF=1 with VSYNC=0 -> latch CAM_DATA as high byte, col=0, go to BYTE_LO.
  - BYTE_LO: HREF=1 -> form pixel, emit write, col+1, go to BYTE_HI.
  - BYTE_HI: HREF=1 -> latch high byte, go to BYTE_LO.
  - HREF falling edge in BYTE_HI or BYTE_LO: end of line.
    - Flag an error if col != WIDTH or the state was BYTE_LO (odd byte count; the half pixel is dropped).
    - row+1, go to WAIT_LINE.
  - VSYNC rising edge in any non-IDLE state:
    - Abort any open line and flag the error.
    - Flag an error if row != HEIGHT.
    - Pulse FRAME_DONE, load FRAME_ERR, FRAME_CNT+1, go to IDLE.
- Pixel pack, with hi/lo = RGB565 bytes: R = hi[7:5], G = hi[2:0], B = lo[4:3]. PIXEL_OUT = {R,G,B}.
- Clipping: a pixel with col >= WIDTH or row >= HEIGHT is not written (W_EN stays 0). It still counts toward the length checks. Counters saturate at 1023.
- HREF=1 while VSYNC=1 is ignored entirely.
- W_ADDR is computed as row*WIDTH+col in 15 bits; its maximum is 25343.

## Timing
- Byte sampled at posedge N with HREF=1. The second byte at N makes W_EN, PIXEL_OUT, X_ADDR, Y_ADDR and W_ADDR valid during cycle N+1 only. Latency is one cycle.
- Between strobes, PIXEL_OUT and the addresses hold their last values.
- The edge on HREF/VSYNC is seen one cycle after the level change, via the _q registers.
- FRAME_DONE is high for exactly the one cycle after the VSYNC rise is detected. FRAME_ERR and FRAME_CNT change in that same cycle.
- Reset values: W_EN=0, PIXEL_OUT=0, X_ADDR=0, Y_ADDR=0, W_ADDR=0, FRAME_DONE=0, FRAME_ERR=0, FRAME_CNT=0, state=IDLE.
- Reset asserted mid-frame: all outputs clear immediately. After release, no writes occur until the next VSYNC falling edge.

## Structure
- Shared package `camera_pkg`:
  - SCREEN_WIDTH=176, SCREEN_HEIGHT=144 (defaults for WIDTH/HEIGHT).
  - FSM state encoding.
  - rgb565_to_rgb332 function, also used by the bench model.
- One sub-module, `sync_edge_detect`: one flop plus rise/fall outputs, with async active-low reset. Instantiate it twice, once for HREF and once for VSYNC.

## Test plan
- Nominal frame: VSYNC fall, then 144 lines of 352 bytes, then VSYNC rise.
  - Required: 25344 W_EN pulses, last W_ADDR=25343, FRAME_DONE once, FRAME_ERR=0, FRAME_CNT=1.
- Pixel pack: bytes 0xE7,0x18.
  - Required: PIXEL_OUT=0xFF, one cycle after the second byte.
  - Bytes 0x00,0x00 -> PIXEL_OUT=0x00.
- Short/odd line: line 5 has 351 bytes.
  - Required: 175 writes on row 5 and FRAME_ERR=1 at frame end.
  - The next frame, if clean, gives FRAME_ERR=0.
- Long line: 360 bytes.
  - Required: writes only for X 0..175; FRAME_ERR=1.
- VSYNC rise mid-line at row 70.
  - Required: FRAME_DONE pulse, FRAME_ERR=1, no further writes until the next VSYNC fall.
- Reset mid-frame at row 40.
  - Required: outputs go to 0 immediately. After release, the rest of the frame produces no W_EN; the next full frame captures cleanly.
  - FRAME_CNT: counts 255 frames then 256 frames -> FRAME_CNT=255 then 0.
